dmem_arbiter: RTL

//  Shares the single-port data memory between two requesters: port 0 = CPU load/store

---
 rtl/cpu_pkg.sv | 14 +
 rtl/rr_arbiter2.sv | 22 ++
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and port identifiers for the data-memory arbiter.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port that did not win last.
module rr_arbiter2
  import cpu_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic any_o,
  output logic win_o
);

  always_comb begin
    any_o = req0_i | req1_i;
    win_o = PORT_CPU;
    if (req0_i && req1_i) begin
      win_o = ~last_i;
    end else if (req1_i) begin
      win_o = PORT_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU path (port 0) and the debug/loader
// master (port 1): round-robin req/gnt, one command at a time, fixed-latency read return.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int            CW       = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  arb_state_t    state_q;
  logic          cmd_we_q;
  logic          cmd_port_q;
  logic [AW-1:0] cmd_addr_q;
  logic [DW-1:0] cmd_wdata_q;
  logic          last_winner_q;
  logic [CW-1:0] cnt_q;
  logic          gnt0_q;
  logic          gnt1_q;
  logic          rvalid0_q;
  logic          rvalid1_q;
  logic          mem_en_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  logic          any_req;
  logic          win;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  rr_arbiter2 u_rr (
    .req0_i (m0_req),
    .req1_i (m1_req),
    .last_i (last_winner_q),
    .any_o  (any_req),
    .win_o  (win)
  );

  assign sel_we    = (win == PORT_DBG) ? m1_we    : m0_we;
  assign sel_addr  = (win == PORT_DBG) ? m1_addr  : m0_addr;
  assign sel_wdata = (win == PORT_DBG) ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cmd_we_q      <= 1'b0;
      cmd_port_q    <= PORT_CPU;
      cmd_addr_q    <= '0;
      cmd_wdata_q   <= '0;
      last_winner_q <= PORT_DBG;
      cnt_q         <= '0;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      mem_en_q      <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
    end else begin
      // Strobes are single-cycle pulses unless a state below re-asserts them.
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      mem_en_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            cmd_we_q      <= sel_we;
            cmd_addr_q    <= sel_addr;
            cmd_wdata_q   <= sel_wdata;
            cmd_port_q    <= win;
            last_winner_q <= win;
            gnt0_q        <= (win == PORT_CPU);
            gnt1_q        <= (win == PORT_DBG);
            mem_en_q      <= 1'b1;
            state_q       <= GRANT;
          end
        end
        GRANT: begin
          if (cmd_we_q) begin
            state_q <= IDLE;
          end else begin
            cnt_q   <= CNT_INIT;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // cnt hits zero exactly LATENCY cycles after the strobe, when mem_rdata is valid.
          if (cnt_q == '0) begin
            if (cmd_port_q == PORT_DBG) begin
              rdata1_q  <= mem_rdata;
              rvalid1_q <= 1'b1;
            end else begin
              rdata0_q  <= mem_rdata;
              rvalid0_q <= 1'b1;
            end
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m0_gnt    = gnt0_q;
  assign m1_gnt    = gnt1_q;
  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

  // Memory bus is forced to zero outside the strobe cycle.
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_en_q & cmd_we_q;
  assign mem_addr  = mem_en_q ? cmd_addr_q  : '0;
  assign mem_wdata = mem_en_q ? cmd_wdata_q : '0;
  assign busy      = (state_q != IDLE);

  a_strobe_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({gnt0_q, gnt1_q, rvalid0_q, rvalid1_q}));

endmodule
